// File: rtl/ibex_wb_merge.sv
// Writeback merge: arbitrates load responses and EX results onto one register-file
// write port, tracks pending load destinations and forwards in-flight write data.
module ibex_wb_merge #(
    parameter int unsigned DataWidth = 32,
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned LoadDepth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ex_valid_i,
    output logic                 ex_ready_o,
    input  logic [4:0]           ex_waddr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    input  logic                 ld_issue_i,
    output logic                 ld_ready_o,
    input  logic [4:0]           ld_waddr_i,
    input  logic                 lsu_rvalid_i,
    input  logic                 lsu_err_i,
    input  logic [DataWidth-1:0] lsu_rdata_i,
    output logic                 rf_we_o,
    output logic [4:0]           rf_waddr_o,
    output logic [DataWidth-1:0] rf_wdata_o,
    input  logic [4:0]           raddr_a_i,
    input  logic [DataWidth-1:0] rf_rdata_a_i,
    output logic [DataWidth-1:0] rdata_a_o,
    output logic                 busy_a_o,
    input  logic [4:0]           raddr_b_i,
    input  logic [DataWidth-1:0] rf_rdata_b_i,
    output logic [DataWidth-1:0] rdata_b_o,
    output logic                 busy_b_o
);

    // Queue storage is sized for the largest legal depth; only LoadDepth slots are used.
    localparam int unsigned QMAX  = 4;
    localparam logic [2:0]  DEPTH = 3'(LoadDepth);
    localparam logic [1:0]  LAST  = 2'(LoadDepth - 1);

    logic                 skid_valid_reg, skid_valid_next;
    logic [4:0]           skid_addr_reg, skid_addr_next;
    logic [DataWidth-1:0] skid_data_reg, skid_data_next;

    logic                 rf_we_reg, rf_we_next;
    logic [4:0]           rf_waddr_reg, rf_waddr_next;
    logic [DataWidth-1:0] rf_wdata_reg, rf_wdata_next;

    logic [4:0]           q_addr_reg [QMAX];
    logic [QMAX-1:0]      q_valid_reg;
    logic [1:0]           head_reg, tail_reg;
    logic [2:0]           count_reg;

    logic                 ex_accept, lsu_pop, ld_push;
    logic [4:0]           head_addr;

    function automatic logic keep_write(input logic [4:0] addr);
        return (addr != 5'd0) && !(RV32E && addr[4]);
    endfunction

    function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
        return (ptr == LAST) ? 2'd0 : ptr + 2'd1;
    endfunction

    assign ex_ready_o = !skid_valid_reg;
    assign ld_ready_o = (count_reg < DEPTH);
    assign ex_accept  = ex_valid_i && !skid_valid_reg;
    assign lsu_pop    = lsu_rvalid_i && (count_reg != 3'd0);
    assign ld_push    = ld_issue_i && ld_ready_o;
    assign head_addr  = q_addr_reg[head_reg];

    assign rf_we_o    = rf_we_reg;
    assign rf_waddr_o = rf_waddr_reg;
    assign rf_wdata_o = rf_wdata_reg;

    // Load response wins; an EX request accepted alongside it is parked in the skid buffer.
    always_comb begin
        skid_valid_next = skid_valid_reg;
        skid_addr_next  = skid_addr_reg;
        skid_data_next  = skid_data_reg;
        rf_we_next      = 1'b0;
        rf_waddr_next   = rf_waddr_reg;
        rf_wdata_next   = rf_wdata_reg;
        if (lsu_pop) begin
            rf_we_next    = !lsu_err_i && keep_write(head_addr);
            rf_waddr_next = head_addr;
            rf_wdata_next = lsu_rdata_i;
            if (ex_accept) begin
                skid_valid_next = 1'b1;
                skid_addr_next  = ex_waddr_i;
                skid_data_next  = ex_wdata_i;
            end
        end else if (skid_valid_reg) begin
            rf_we_next      = keep_write(skid_addr_reg);
            rf_waddr_next   = skid_addr_reg;
            rf_wdata_next   = skid_data_reg;
            skid_valid_next = 1'b0;
        end else if (ex_accept) begin
            rf_we_next    = keep_write(ex_waddr_i);
            rf_waddr_next = ex_waddr_i;
            rf_wdata_next = ex_wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            skid_valid_reg <= 1'b0;
            skid_addr_reg  <= 5'd0;
            skid_data_reg  <= '0;
            rf_we_reg      <= 1'b0;
            rf_waddr_reg   <= 5'd0;
            rf_wdata_reg   <= '0;
        end else begin
            skid_valid_reg <= skid_valid_next;
            skid_addr_reg  <= skid_addr_next;
            skid_data_reg  <= skid_data_next;
            rf_we_reg      <= rf_we_next;
            rf_waddr_reg   <= rf_waddr_next;
            rf_wdata_reg   <= rf_wdata_next;
        end
    end

    // Push and pop never touch the same slot: that would need the queue both empty and full.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < QMAX; i++) begin
                q_addr_reg[i] <= 5'd0;
            end
            q_valid_reg <= '0;
            head_reg    <= 2'd0;
            tail_reg    <= 2'd0;
            count_reg   <= 3'd0;
        end else begin
            if (lsu_pop) begin
                q_valid_reg[head_reg] <= 1'b0;
                head_reg              <= ptr_inc(head_reg);
            end
            if (ld_push) begin
                q_addr_reg[tail_reg]  <= ld_waddr_i;
                q_valid_reg[tail_reg] <= 1'b1;
                tail_reg              <= ptr_inc(tail_reg);
            end
            count_reg <= count_reg + {2'b00, ld_push} - {2'b00, lsu_pop};
        end
    end

    logic [4:0]           raddr     [2];
    logic [DataWidth-1:0] rf_rdata  [2];
    logic [DataWidth-1:0] fwd_rdata [2];
    logic [1:0]           busy;

    assign raddr[0]    = raddr_a_i;
    assign raddr[1]    = raddr_b_i;
    assign rf_rdata[0] = rf_rdata_a_i;
    assign rf_rdata[1] = rf_rdata_b_i;
    assign rdata_a_o   = fwd_rdata[0];
    assign rdata_b_o   = fwd_rdata[1];
    assign busy_a_o    = busy[0];
    assign busy_b_o    = busy[1];

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        logic [QMAX-1:0] hit;
        for (genvar gj = 0; gj < QMAX; gj++) begin : g_slot
            assign hit[gj] = q_valid_reg[gj] && (q_addr_reg[gj] == raddr[gi]);
        end
        assign busy[gi] = (raddr[gi] != 5'd0) && (|hit);

        // Skid buffer holds the younger instruction, so it shadows the output register.
        always_comb begin
            fwd_rdata[gi] = rf_rdata[gi];
            if (raddr[gi] == 5'd0) begin
                fwd_rdata[gi] = '0;
            end else if (skid_valid_reg && (skid_addr_reg == raddr[gi])) begin
                fwd_rdata[gi] = skid_data_reg;
            end else if (rf_we_reg && (rf_waddr_reg == raddr[gi])) begin
                fwd_rdata[gi] = rf_wdata_reg;
            end
        end
    end

endmodule

// File: tb/tb_ibex_wb_merge.sv
// Directed bench for ibex_wb_merge: a vector table for the default configuration plus
// hand sequences for RV32E dropping and mid-operation reset.
module tb_ibex_wb_merge;

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;

    // Default instance: RV32I, two-entry load queue
    logic        ex_valid, ex_ready, ld_issue, ld_ready, lsu_rvalid, lsu_err;
    logic [4:0]  ex_waddr, ld_waddr, raddr_a, raddr_b, rf_waddr;
    logic [31:0] ex_wdata, lsu_rdata, rf_rdata_a, rf_rdata_b, rdata_a, rdata_b, rf_wdata;
    logic        rf_we, busy_a, busy_b;

    // Second instance: RV32E, four-entry load queue
    logic        e_ex_valid, e_ex_ready, e_ld_issue, e_ld_ready, e_lsu_rvalid, e_lsu_err;
    logic [4:0]  e_ex_waddr, e_ld_waddr, e_raddr_a, e_raddr_b, e_rf_waddr;
    logic [31:0] e_ex_wdata, e_lsu_rdata, e_rf_rdata_a, e_rf_rdata_b, e_rdata_a, e_rdata_b, e_rf_wdata;
    logic        e_rf_we, e_busy_a, e_busy_b;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    ibex_wb_merge #(.DataWidth(32), .RV32E(1'b0), .LoadDepth(2)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ex_valid_i(ex_valid), .ex_ready_o(ex_ready), .ex_waddr_i(ex_waddr), .ex_wdata_i(ex_wdata),
        .ld_issue_i(ld_issue), .ld_ready_o(ld_ready), .ld_waddr_i(ld_waddr),
        .lsu_rvalid_i(lsu_rvalid), .lsu_err_i(lsu_err), .lsu_rdata_i(lsu_rdata),
        .rf_we_o(rf_we), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata),
        .raddr_a_i(raddr_a), .rf_rdata_a_i(rf_rdata_a), .rdata_a_o(rdata_a), .busy_a_o(busy_a),
        .raddr_b_i(raddr_b), .rf_rdata_b_i(rf_rdata_b), .rdata_b_o(rdata_b), .busy_b_o(busy_b)
    );

    ibex_wb_merge #(.DataWidth(32), .RV32E(1'b1), .LoadDepth(4)) u_dut_e (
        .clk_i(clk_i), .rst_i(rst_i),
        .ex_valid_i(e_ex_valid), .ex_ready_o(e_ex_ready), .ex_waddr_i(e_ex_waddr), .ex_wdata_i(e_ex_wdata),
        .ld_issue_i(e_ld_issue), .ld_ready_o(e_ld_ready), .ld_waddr_i(e_ld_waddr),
        .lsu_rvalid_i(e_lsu_rvalid), .lsu_err_i(e_lsu_err), .lsu_rdata_i(e_lsu_rdata),
        .rf_we_o(e_rf_we), .rf_waddr_o(e_rf_waddr), .rf_wdata_o(e_rf_wdata),
        .raddr_a_i(e_raddr_a), .rf_rdata_a_i(e_rf_rdata_a), .rdata_a_o(e_rdata_a), .busy_a_o(e_busy_a),
        .raddr_b_i(e_raddr_b), .rf_rdata_b_i(e_rf_rdata_b), .rdata_b_o(e_rdata_b), .busy_b_o(e_busy_b)
    );

    typedef struct {
        logic ex_v; logic [4:0] ex_a; logic [31:0] ex_d;
        logic ld_v; logic [4:0] ld_a;
        logic rv; logic err; logic [31:0] rd;
        logic [4:0] ra; logic [31:0] rfa; logic [4:0] rb; logic [31:0] rfb;
        logic x_exr; logic x_ldr; logic x_ba; logic x_bb; logic [31:0] x_da; logic [31:0] x_db;
        logic x_we; logic [4:0] x_wa; logic [31:0] x_wd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic idle_main();
        ex_valid = 0; ex_waddr = 0; ex_wdata = 0; ld_issue = 0; ld_waddr = 0;
        lsu_rvalid = 0; lsu_err = 0; lsu_rdata = 0;
        raddr_a = 0; rf_rdata_a = 0; raddr_b = 0; rf_rdata_b = 0;
    endtask

    task automatic idle_e();
        e_ex_valid = 0; e_ex_waddr = 0; e_ex_wdata = 0; e_ld_issue = 0; e_ld_waddr = 0;
        e_lsu_rvalid = 0; e_lsu_err = 0; e_lsu_rdata = 0;
        e_raddr_a = 0; e_rf_rdata_a = 0; e_raddr_b = 0; e_rf_rdata_b = 0;
    endtask

    // Write-after-write guard: EX must never target a register with a pending load.
    int pend[$];
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend.delete();
        end else begin
            if (ex_valid && ex_ready && ex_waddr != 5'd0) begin
                foreach (pend[k]) begin
                    if (pend[k] == int'(ex_waddr)) begin
                        errors++;
                        $display("FAIL waw: EX write to x%0d with pending load, expected no overlap", ex_waddr);
                    end
                end
            end
            if (lsu_rvalid && pend.size() > 0) void'(pend.pop_front());
            if (ld_issue && ld_ready) pend.push_back(int'(ld_waddr));
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        idle_main();
        idle_e();

        // ex_v ex_a ex_d | ld_v ld_a | rv err rd | ra rfa rb rfb | exr ldr ba bb da db | we wa wd
        vecs.push_back(vec_t'{Y,5'd5,32'hDEADBEEF, N,5'd0, N,N,32'h0,  5'd0,32'h0, 5'd0,32'h0,   Y,Y,N,N,32'h0,32'h0,        Y,5'd5,32'hDEADBEEF});
        vecs.push_back(vec_t'{N,5'd0,32'h0,        N,5'd0, N,N,32'h0,  5'd5,32'h0, 5'd0,32'h0,   Y,Y,N,N,32'hDEADBEEF,32'h0, N,5'd0,32'h0});
        vecs.push_back(vec_t'{N,5'd0,32'h0,        Y,5'd7, N,N,32'h0,  5'd0,32'h0, 5'd0,32'h0,   Y,Y,N,N,32'h0,32'h0,        N,5'd0,32'h0});
        vecs.push_back(vec_t'{Y,5'd3,32'h33,       N,5'd0, Y,N,32'h11, 5'd7,32'h77,5'd0,32'h0,   Y,Y,Y,N,32'h77,32'h0,       Y,5'd7,32'h11});
        vecs.push_back(vec_t'{N,5'd0,32'h0,        N,5'd0, N,N,32'h0,  5'd3,32'h0, 5'd7,32'h0,   N,Y,N,N,32'h33,32'h11,      Y,5'd3,32'h33});
        vecs.push_back(vec_t'{N,5'd0,32'h0,        N,5'd0, N,N,32'h0,  5'd3,32'h0, 5'd0,32'h0,   Y,Y,N,N,32'h33,32'h0,       N,5'd0,32'h0});
        vecs.push_back(vec_t'{N,5'd0,32'h0,        Y,5'd1, N,N,32'h0,  5'd0,32'h0, 5'd0,32'h0,   Y,Y,N,N,32'h0,32'h0,        N,5'd0,32'h0});
        vecs.push_back(vec_t'{N,5'd0,32'h0,        Y,5'd2, N,N,32'h0,  5'd0,32'h0, 5'd0,32'h0,   Y,Y,N,N,32'h0,32'h0,        N,5'd0,32'h0});
        vecs.push_back(vec_t'{N,5'd0,32'h0,        Y,5'd6, N,N,32'h0,  5'd2,32'h22,5'd6,32'h66,  Y,N,Y,N,32'h22,32'h66,      N,5'd0,32'h0});
        vecs.push_back(vec_t'{N,5'd0,32'h0,        N,5'd0, Y,N,32'hA,  5'd2,32'h22,5'd0,32'h0,   Y,N,Y,N,32'h22,32'h0,       Y,5'd1,32'hA});
        vecs.push_back(vec_t'{N,5'd0,32'h0,        N,5'd0, Y,N,32'hB,  5'd2,32'h22,5'd0,32'h0,   Y,Y,Y,N,32'h22,32'h0,       Y,5'd2,32'hB});
        vecs.push_back(vec_t'{N,5'd0,32'h0,        N,5'd0, N,N,32'h0,  5'd2,32'h22,5'd6,32'h66,  Y,Y,N,N,32'hB,32'h66,       N,5'd0,32'h0});
        vecs.push_back(vec_t'{N,5'd0,32'h0,        N,5'd0, Y,N,32'hCC, 5'd0,32'h0, 5'd0,32'h0,   Y,Y,N,N,32'h0,32'h0,        N,5'd0,32'h0});
        vecs.push_back(vec_t'{Y,5'd9,32'h55,       N,5'd0, N,N,32'h0,  5'd0,32'h0, 5'd0,32'h0,   Y,Y,N,N,32'h0,32'h0,        Y,5'd9,32'h55});
        vecs.push_back(vec_t'{N,5'd0,32'h0,        N,5'd0, N,N,32'h0,  5'd9,32'h0, 5'd0,32'h99,  Y,Y,N,N,32'h55,32'h0,       N,5'd0,32'h0});
        vecs.push_back(vec_t'{Y,5'd0,32'h12,       N,5'd0, N,N,32'h0,  5'd0,32'h0, 5'd0,32'h0,   Y,Y,N,N,32'h0,32'h0,        N,5'd0,32'h0});
        vecs.push_back(vec_t'{N,5'd0,32'h0,        Y,5'd0, N,N,32'h0,  5'd0,32'h0, 5'd0,32'h0,   Y,Y,N,N,32'h0,32'h0,        N,5'd0,32'h0});
        vecs.push_back(vec_t'{N,5'd0,32'h0,        Y,5'd0, N,N,32'h0,  5'd0,32'h0, 5'd0,32'h0,   Y,Y,N,N,32'h0,32'h0,        N,5'd0,32'h0});
        vecs.push_back(vec_t'{N,5'd0,32'h0,        N,5'd0, Y,N,32'h34, 5'd0,32'h0, 5'd0,32'h0,   Y,N,N,N,32'h0,32'h0,        N,5'd0,32'h0});
        vecs.push_back(vec_t'{N,5'd0,32'h0,        N,5'd0, Y,N,32'h35, 5'd0,32'h0, 5'd0,32'h0,   Y,Y,N,N,32'h0,32'h0,        N,5'd0,32'h0});
        vecs.push_back(vec_t'{N,5'd0,32'h0,        Y,5'd8, N,N,32'h0,  5'd0,32'h0, 5'd0,32'h0,   Y,Y,N,N,32'h0,32'h0,        N,5'd0,32'h0});
        vecs.push_back(vec_t'{N,5'd0,32'h0,        N,5'd0, Y,Y,32'h88, 5'd8,32'h80,5'd0,32'h0,   Y,Y,Y,N,32'h80,32'h0,       N,5'd0,32'h0});
        vecs.push_back(vec_t'{N,5'd0,32'h0,        N,5'd0, N,N,32'h0,  5'd8,32'h80,5'd0,32'h0,   Y,Y,N,N,32'h80,32'h0,       N,5'd0,32'h0});
        vecs.push_back(vec_t'{N,5'd0,32'h0,        Y,5'd10,N,N,32'h0,  5'd0,32'h0, 5'd0,32'h0,   Y,Y,N,N,32'h0,32'h0,        N,5'd0,32'h0});
        vecs.push_back(vec_t'{N,5'd0,32'h0,        Y,5'd11,Y,N,32'h1A, 5'd0,32'h0, 5'd0,32'h0,   Y,Y,N,N,32'h0,32'h0,        Y,5'd10,32'h1A});
        vecs.push_back(vec_t'{N,5'd0,32'h0,        N,5'd0, N,N,32'h0,  5'd11,32'h0,5'd10,32'h0,  Y,Y,Y,N,32'h0,32'h1A,       N,5'd0,32'h0});
        vecs.push_back(vec_t'{N,5'd0,32'h0,        N,5'd0, Y,N,32'h1B, 5'd0,32'h0, 5'd0,32'h0,   Y,Y,N,N,32'h0,32'h0,        Y,5'd11,32'h1B});
        vecs.push_back(vec_t'{N,5'd0,32'h0,        Y,5'd12,N,N,32'h0,  5'd0,32'h0, 5'd0,32'h0,   Y,Y,N,N,32'h0,32'h0,        N,5'd0,32'h0});
        vecs.push_back(vec_t'{Y,5'd13,32'hD1,      N,5'd0, Y,N,32'hC1, 5'd0,32'h0, 5'd0,32'h0,   Y,Y,N,N,32'h0,32'h0,        Y,5'd12,32'hC1});
        vecs.push_back(vec_t'{Y,5'd14,32'hE1,      N,5'd0, N,N,32'h0,  5'd13,32'h0,5'd12,32'h0,  N,Y,N,N,32'hD1,32'hC1,      Y,5'd13,32'hD1});
        vecs.push_back(vec_t'{Y,5'd14,32'hE1,      N,5'd0, N,N,32'h0,  5'd0,32'h0, 5'd0,32'h0,   Y,Y,N,N,32'h0,32'h0,        Y,5'd14,32'hE1});

        // Reset state
        #2;
        chk("reset.rf_we", 32'(rf_we), 32'h0);
        chk("reset.rf_waddr", 32'(rf_waddr), 32'h0);
        chk("reset.rf_wdata", rf_wdata, 32'h0);
        chk("reset.ex_ready", 32'(ex_ready), 32'h1);
        chk("reset.ld_ready", 32'(ld_ready), 32'h1);
        @(negedge clk_i);
        rst_i = 1'b0;

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            @(negedge clk_i);
            ex_valid = v.ex_v; ex_waddr = v.ex_a; ex_wdata = v.ex_d;
            ld_issue = v.ld_v; ld_waddr = v.ld_a;
            lsu_rvalid = v.rv; lsu_err = v.err; lsu_rdata = v.rd;
            raddr_a = v.ra; rf_rdata_a = v.rfa; raddr_b = v.rb; rf_rdata_b = v.rfb;
            #1;
            chk($sformatf("v%0d.ex_ready", i), 32'(ex_ready), 32'(v.x_exr));
            chk($sformatf("v%0d.ld_ready", i), 32'(ld_ready), 32'(v.x_ldr));
            chk($sformatf("v%0d.busy_a", i), 32'(busy_a), 32'(v.x_ba));
            chk($sformatf("v%0d.busy_b", i), 32'(busy_b), 32'(v.x_bb));
            chk($sformatf("v%0d.rdata_a", i), rdata_a, v.x_da);
            chk($sformatf("v%0d.rdata_b", i), rdata_b, v.x_db);
            @(posedge clk_i);
            #1;
            chk($sformatf("v%0d.rf_we", i), 32'(rf_we), 32'(v.x_we));
            if (v.x_we) begin
                chk($sformatf("v%0d.rf_waddr", i), 32'(rf_waddr), 32'(v.x_wa));
                chk($sformatf("v%0d.rf_wdata", i), rf_wdata, v.x_wd);
            end
        end
        @(negedge clk_i);
        idle_main();

        // RV32E: x20 dropped, x4 written, load to x17 pops without a write
        e_ex_valid = 1; e_ex_waddr = 5'd20; e_ex_wdata = 32'h20;
        @(posedge clk_i); #1;
        chk("e.x20.rf_we", 32'(e_rf_we), 32'h0);
        @(negedge clk_i);
        e_ex_waddr = 5'd4; e_ex_wdata = 32'h44;
        @(posedge clk_i); #1;
        chk("e.x4.rf_we", 32'(e_rf_we), 32'h1);
        chk("e.x4.rf_waddr", 32'(e_rf_waddr), 32'd4);
        chk("e.x4.rf_wdata", e_rf_wdata, 32'h44);
        @(negedge clk_i);
        idle_e();
        e_ld_issue = 1; e_ld_waddr = 5'd17;
        @(negedge clk_i);
        idle_e();
        e_raddr_a = 5'd17;
        #1;
        chk("e.x17.busy_a", 32'(e_busy_a), 32'h1);
        e_lsu_rvalid = 1; e_lsu_rdata = 32'h17;
        @(posedge clk_i); #1;
        chk("e.x17.rf_we", 32'(e_rf_we), 32'h0);
        chk("e.x17.busy_after", 32'(e_busy_a), 32'h0);
        @(negedge clk_i);
        idle_e();

        // Build up queue and skid state, then reset mid-cycle
        ld_issue = 1; ld_waddr = 5'd1; e_ld_issue = 1; e_ld_waddr = 5'd1;
        @(negedge clk_i);
        ld_waddr = 5'd2; e_ld_waddr = 5'd2;
        @(negedge clk_i);
        idle_main();
        e_ld_issue = 1; e_ld_waddr = 5'd3;
        e_lsu_rvalid = 1; e_lsu_rdata = 32'h5A;
        e_ex_valid = 1; e_ex_waddr = 5'd5; e_ex_wdata = 32'h55;
        @(posedge clk_i); #1;
        chk("pre_rst.e.rf_we", 32'(e_rf_we), 32'h1);
        chk("pre_rst.e.rf_wdata", e_rf_wdata, 32'h5A);
        chk("pre_rst.e.ex_ready", 32'(e_ex_ready), 32'h0);
        chk("pre_rst.ld_ready", 32'(ld_ready), 32'h0);
        idle_e();
        raddr_a = 5'd2; e_raddr_b = 5'd3; e_raddr_a = 5'd5;
        #1;
        chk("pre_rst.busy_a", 32'(busy_a), 32'h1);
        chk("pre_rst.e.busy_b", 32'(e_busy_b), 32'h1);
        chk("pre_rst.e.rdata_a", e_rdata_a, 32'h55);
        #1;
        rst_i = 1'b1;
        #1;
        chk("rst.ld_ready", 32'(ld_ready), 32'h1);
        chk("rst.busy_a", 32'(busy_a), 32'h0);
        chk("rst.e.ex_ready", 32'(e_ex_ready), 32'h1);
        chk("rst.e.rf_we", 32'(e_rf_we), 32'h0);
        chk("rst.e.busy_b", 32'(e_busy_b), 32'h0);
        chk("rst.e.rdata_a", e_rdata_a, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        lsu_rvalid = 1; lsu_rdata = 32'h77;
        e_lsu_rvalid = 1; e_lsu_rdata = 32'h78;
        @(posedge clk_i); #1;
        chk("post_rst.rf_we", 32'(rf_we), 32'h0);
        chk("post_rst.e.rf_we", 32'(e_rf_we), 32'h0);
        @(negedge clk_i);
        idle_main();
        idle_e();
        @(negedge clk_i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
